// File: rtl/wb_regfile_csr_v2.sv
// Writeback stage: GPR file, machine-mode CSRs, ecall/mret redirect.
// Optional macro WB_REGFILE_BYPASS_EN forwards the committing GPR write to same-cycle reads.
module wb_regfile_csr_v2 #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int PC_W   = 32,
  parameter int HARTID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_to_wb_valid,
  input  logic                 mem_flush,
  output logic                 wb_allowin,
  input  logic                 wb_stall,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_reg_wen,
  input  logic [XLEN-1:0]      in_wdata,
  input  logic [11:0]          in_csr_addr,
  input  logic [1:0]           in_csr_op,
  input  logic                 in_csr_imm,
  input  logic [4:0]           in_rs1,
  input  logic [XLEN-1:0]      in_csr_src,
  input  logic                 in_ecall,
  input  logic                 in_mret,
  input  logic [NRP*AW-1:0]    raddr,
  output logic [NRP*XLEN-1:0]  rdata,
  output logic                 wb_valid,
  output logic                 wb_commit,
  output logic [PC_W-1:0]      wb_pc,
  output logic [AW-1:0]        wb_rd,
  output logic                 wb_reg_wen,
  output logic [XLEN-1:0]      wb_reg_wdata,
  output logic                 redirect,
  output logic [PC_W-1:0]      redirect_pc,
  output logic [XLEN-1:0]      csr_mstatus,
  output logic [XLEN-1:0]      csr_mepc,
  output logic [XLEN-1:0]      csr_mtvec,
  output logic [XLEN-1:0]      csr_mcause
);

  typedef enum logic [1:0] {CSR_NONE = 2'd0, CSR_RW = 2'd1, CSR_RS = 2'd2, CSR_RC = 2'd3} csr_op_e;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic            wen_q;
  logic [XLEN-1:0] wdata_q;
  logic [11:0]     csr_addr_q;
  csr_op_e         csr_op_q;
  logic            csr_imm_q;
  logic [4:0]      rs1_q;
  logic [XLEN-1:0] csr_src_q;
  logic            ecall_q;
  logic            mret_q;

  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_r, mip_r, mscratch_r, mepc_r, mtvec_r, mcause_r;
  logic [XLEN-1:0] csr_old, csr_new, csr_src_sel;
  logic            csr_we;

  logic [XLEN-1:0] rf [NREG];

  assign wb_allowin = !wb_valid || !wb_stall;
  assign wb_commit  = wb_valid && !wb_stall;
  assign wb_reg_wen = wen_q && (wb_rd != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      wb_rd      <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      csr_addr_q <= '0;
      csr_op_q   <= CSR_NONE;
      csr_imm_q  <= 1'b0;
      rs1_q      <= '0;
      csr_src_q  <= '0;
      ecall_q    <= 1'b0;
      mret_q     <= 1'b0;
    end else begin
      if (wb_allowin) wb_valid <= mem_to_wb_valid && !mem_flush;
      if (mem_to_wb_valid && wb_allowin) begin
        wb_pc      <= in_pc;
        wb_rd      <= in_rd;
        wen_q      <= in_reg_wen;
        wdata_q    <= in_wdata;
        csr_addr_q <= in_csr_addr;
        csr_op_q   <= csr_op_e'(in_csr_op);
        csr_imm_q  <= in_csr_imm;
        rs1_q      <= in_rs1;
        csr_src_q  <= in_csr_src;
        ecall_q    <= in_ecall;
        mret_q     <= in_mret;
      end
    end
  end

  assign csr_mstatus = XLEN'({2'b11, 3'b000, st_mpie, 3'b000, st_mie, 3'b000});
  assign csr_mepc    = mepc_r;
  assign csr_mtvec   = mtvec_r;
  assign csr_mcause  = mcause_r;

  always_comb begin
    // NOTE: default first so every path assigns csr_old and no latch is inferred.
    csr_old = '0;
    case (csr_addr_q)
      A_MSTATUS:  csr_old = csr_mstatus;
      A_MIE:      csr_old = mie_r;
      A_MTVEC:    csr_old = mtvec_r;
      A_MSCRATCH: csr_old = mscratch_r;
      A_MEPC:     csr_old = mepc_r;
      A_MCAUSE:   csr_old = mcause_r;
      A_MIP:      csr_old = mip_r;
      A_MHARTID:  csr_old = XLEN'(HARTID);
      default:    csr_old = '0;
    endcase
  end

  assign csr_src_sel = csr_imm_q ? XLEN'(rs1_q) : csr_src_q;

  always_comb begin
    csr_new = csr_src_sel;
    case (csr_op_q)
      CSR_RS:  csr_new = csr_old | csr_src_sel;
      CSR_RC:  csr_new = csr_old & ~csr_src_sel;
      default: csr_new = csr_src_sel;
    endcase
  end

  // Set/clear with a zero rs1 field is a pure read; trap flags override any CSR op.
  assign csr_we = wb_commit && !ecall_q && !mret_q && (csr_op_q != CSR_NONE) &&
                  ((csr_op_q == CSR_RW) || (rs1_q != '0));

  assign wb_reg_wdata = (csr_op_q != CSR_NONE) ? csr_old : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      mie_r       <= '0;
      mip_r       <= '0;
      mscratch_r  <= '0;
      mepc_r      <= '0;
      mtvec_r     <= '0;
      mcause_r    <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= wb_commit && (ecall_q || mret_q);
      if (wb_commit && ecall_q) begin
        mepc_r      <= XLEN'(wb_pc);
        mcause_r    <= XLEN'(11);
        st_mpie     <= st_mie;
        st_mie      <= 1'b0;
        redirect_pc <= mtvec_r[PC_W-1:0];
      end else if (wb_commit && mret_q) begin
        st_mie      <= st_mpie;
        st_mpie     <= 1'b1;
        redirect_pc <= mepc_r[PC_W-1:0];
      end else if (csr_we) begin
        case (csr_addr_q)
          A_MSTATUS: begin
            st_mie  <= csr_new[3];
            st_mpie <= csr_new[7];
          end
          A_MIE:      mie_r      <= csr_new;
          A_MTVEC:    mtvec_r    <= csr_new;
          A_MSCRATCH: mscratch_r <= csr_new;
          A_MEPC:     mepc_r     <= csr_new;
          A_MCAUSE:   mcause_r   <= csr_new;
          A_MIP:      mip_r      <= csr_new;
          default:    ;
        endcase
      end
    end
  end

  // NOTE: the register array has no reset so it can map onto RAM; x0 is masked on read.
  always_ff @(posedge clk) begin
    if (!rst && wb_commit && wb_reg_wen) rf[wb_rd] <= wb_reg_wdata;
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    assign ra = raddr[gi*AW +: AW];
    always_comb begin
      rv = (ra == '0) ? '0 : rf[ra];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_commit && wb_reg_wen && (ra == wb_rd)) rv = wb_reg_wdata;
`endif
    end
    assign rdata[gi*XLEN +: XLEN] = rv;
  end

endmodule

// File: tb/tb_wb_regfile_csr_v2.sv
// Randomized bench for wb_regfile_csr_v2 against an instruction-level reference model.
module tb_wb_regfile_csr_v2;
  localparam int XLEN = 64, NREG = 32, AW = 5, NRP = 2, PC_W = 32, HARTID = 0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [AW-1:0]   rd;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic [11:0]     addr;
    logic [1:0]      op;
    logic            imm;
    logic [4:0]      rs1;
    logic [XLEN-1:0] src;
    logic            ecall;
    logic            mret;
  } instr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, flush, stall;
  instr_t cur;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic wb_allowin, wb_valid, wb_commit, wb_reg_wen, redirect;
  logic [PC_W-1:0] wb_pc, redirect_pc;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_reg_wdata, csr_mstatus, csr_mepc, csr_mtvec, csr_mcause;

  wb_regfile_csr_v2 #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .PC_W(PC_W), .HARTID(HARTID)) dut (
    .clk(clk), .rst(rst), .mem_to_wb_valid(in_valid), .mem_flush(flush), .wb_allowin(wb_allowin),
    .wb_stall(stall), .in_pc(cur.pc), .in_rd(cur.rd), .in_reg_wen(cur.wen), .in_wdata(cur.wdata),
    .in_csr_addr(cur.addr), .in_csr_op(cur.op), .in_csr_imm(cur.imm), .in_rs1(cur.rs1),
    .in_csr_src(cur.src), .in_ecall(cur.ecall), .in_mret(cur.mret), .raddr(raddr), .rdata(rdata),
    .wb_valid(wb_valid), .wb_commit(wb_commit), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
    .wb_reg_wdata(wb_reg_wdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec), .csr_mcause(csr_mcause)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: architectural registers plus the one instruction held in WB.
  logic [XLEN-1:0] m_gpr [NREG];
  logic            m_known [NREG];
  logic            m_valid, m_redirect, m_st_mie, m_st_mpie;
  logic [PC_W-1:0] m_rpc;
  logic [XLEN-1:0] m_mie_r, m_mip, m_mscratch, m_mtvec, m_mepc, m_mcause;
  instr_t          m_slot;

  logic [11:0] csr_addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h344, 12'hF14, 12'h7C0};

  function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (m_st_mpie ? 64'h80 : 64'h0) + (m_st_mie ? 64'h8 : 64'h0);
      12'h304: return m_mie_r;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hF14: return 64'(HARTID);
      default: return 64'h0;
    endcase
  endfunction

  task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] v);
    case (a)
      12'h300: begin m_st_mie = v[3]; m_st_mpie = v[7]; end
      12'h304: m_mie_r = v;
      12'h305: m_mtvec = v;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v;
      12'h342: m_mcause = v;
      12'h344: m_mip = v;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_valid = 0; m_redirect = 0; m_rpc = '0; m_slot = '0;
    m_st_mie = 0; m_st_mpie = 0;
    m_mie_r = '0; m_mip = '0; m_mscratch = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
  endtask

  task automatic model_commit(input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] old, src, nv;
    old = csr_read(m_slot.addr);
    src = m_slot.imm ? {59'b0, m_slot.rs1} : m_slot.src;
    if (m_slot.ecall) begin
      m_redirect = 1; m_rpc = m_mtvec[PC_W-1:0];
      m_mepc = {32'b0, m_slot.pc}; m_mcause = 64'd11;
      m_st_mpie = m_st_mie; m_st_mie = 0;
    end else if (m_slot.mret) begin
      m_redirect = 1; m_rpc = m_mepc[PC_W-1:0];
      m_st_mie = m_st_mpie; m_st_mpie = 1;
    end else if (m_slot.op != 2'd0 && (m_slot.op == 2'd1 || m_slot.rs1 != 5'd0)) begin
      case (m_slot.op)
        2'd1:    nv = src;
        2'd2:    nv = old | src;
        default: nv = old & ~src;
      endcase
      csr_write(m_slot.addr, nv);
    end
    if (m_slot.wen && m_slot.rd != 0) begin
      m_gpr[m_slot.rd] = wd;
      m_known[m_slot.rd] = 1;
    end
  endtask

  // Called at a negedge with the cycle's inputs applied; checks, advances the model, moves one cycle.
  task automatic step();
    logic m_allow, m_commit, hit;
    logic [XLEN-1:0] wd, e;
    logic [AW-1:0] a;
    #1;
    m_allow  = !m_valid || !stall;
    m_commit = m_valid && !stall;
    wd = (m_slot.op != 2'd0) ? csr_read(m_slot.addr) : m_slot.wdata;
    check("wb_allowin", wb_allowin, m_allow);
    check("wb_commit", wb_commit, m_commit);
    check("wb_valid", wb_valid, m_valid);
    check("wb_pc", wb_pc, m_slot.pc);
    check("wb_rd", wb_rd, m_slot.rd);
    check("wb_reg_wen", wb_reg_wen, m_slot.wen && m_slot.rd != 0);
    if (m_valid) check("wb_reg_wdata", wb_reg_wdata, wd);
    check("redirect", redirect, m_redirect);
    check("redirect_pc", redirect_pc, m_rpc);
    check("mstatus", csr_mstatus, csr_read(12'h300));
    check("mepc", csr_mepc, m_mepc);
    check("mtvec", csr_mtvec, m_mtvec);
    check("mcause", csr_mcause, m_mcause);
    for (int p = 0; p < NRP; p++) begin
      a = raddr[p*AW +: AW];
      hit = 0; e = '0;
      if (a == 0) hit = 1;
      else begin
        if (m_known[a]) begin e = m_gpr[a]; hit = 1; end
`ifdef WB_REGFILE_BYPASS_EN
        if (m_commit && m_slot.wen && m_slot.rd == a) begin e = wd; hit = 1; end
`endif
      end
      if (hit) check($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], e);
    end
    if (rst) model_reset();
    else begin
      m_redirect = 0;
      if (m_commit) model_commit(wd);
      if (m_allow) m_valid = in_valid && !flush;
      if (in_valid && m_allow) m_slot = cur;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input instr_t i);
    cur = i; in_valid = 1; flush = 0; stall = 0;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 0; flush = 0; stall = 0;
    repeat (n) step();
  endtask

  task automatic read_check(input string tag, input int port, input logic [AW-1:0] r,
                            input logic [XLEN-1:0] exp);
    raddr[port*AW +: AW] = r;
    #1;
    check(tag, rdata[port*XLEN +: XLEN], exp);
  endtask

  function automatic instr_t mk_alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] wdata);
    instr_t i = '0;
    i.pc = 32'h8000_0000 + {25'b0, rd, 2'b0};
    i.rd = rd; i.wen = 1; i.wdata = wdata;
    return i;
  endfunction

  function automatic instr_t mk_csr(input logic [AW-1:0] rd, input logic [11:0] addr, input logic [1:0] op,
                                    input logic [4:0] rs1, input logic [XLEN-1:0] src);
    instr_t i = '0;
    i.pc = 32'h8000_1000; i.rd = rd; i.wen = 1;
    i.addr = addr; i.op = op; i.rs1 = rs1; i.src = src;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    i.pc    = $urandom & 32'hFFFF_FFFC;
    i.rd    = AW'($urandom_range(0, 31));
    i.wen   = $urandom_range(0, 3) != 0;
    i.wdata = {$urandom, $urandom};
    i.addr  = csr_addrs[$urandom_range(0, 8)];
    i.op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    i.imm   = 1'($urandom_range(0, 1));
    i.rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.src   = {$urandom, $urandom};
    k = $urandom_range(0, 19);
    i.ecall = (k == 0);
    i.mret  = (k == 1);
    return i;
  endfunction

  instr_t t;
  logic [XLEN-1:0] saved;

  initial begin
    for (int r = 0; r < NREG; r++) m_known[r] = 0;
    rst = 1; in_valid = 0; flush = 0; stall = 0; cur = '0; raddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_redirect", redirect, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_wb_reg_wen", wb_reg_wen, 0);
    check("rst_mstatus", csr_mstatus, 64'h1800);
    check("rst_mtvec", csr_mtvec, 0);
    check("rst_mepc", csr_mepc, 0);
    check("rst_mcause", csr_mcause, 0);
    rst = 0;

    for (int r = 1; r < NREG; r++) issue(mk_alu(AW'(r), {32'hC0DE_0000 | 32'(r), $urandom}));
    idle(2);

    // Back-to-back writes to one register, then a write to x0.
    issue(mk_alu(5, 64'h1234));
    issue(mk_alu(5, 64'hBEEF));
    idle(2);
    read_check("x5_last_write", 0, 5, 64'hBEEF);
    issue(mk_alu(0, 64'hFF));
    idle(2);
    read_check("x0_reads_zero", 0, 0, 64'h0);

    // Stall holds the WB payload; exactly the held and the next instruction commit.
    t = mk_alu(12, 64'hA5A5_0012);
    issue(t);
    cur = mk_alu(13, 64'hA5A5_0013); in_valid = 1; stall = 1;
    for (int s = 0; s < 3; s++) begin
      step();
      check("stall_allowin", wb_allowin, 0);
      check("stall_wb_pc", wb_pc, t.pc);
    end
    stall = 0;
    step();
    idle(2);
    read_check("stall_x12", 0, 12, 64'hA5A5_0012);
    read_check("stall_x13", 1, 13, 64'hA5A5_0013);

    // Flushed instruction never commits.
    saved = m_gpr[7];
    cur = mk_alu(7, 64'hDEAD); in_valid = 1; flush = 1; stall = 0;
    step();
    check("flush_wb_valid", wb_valid, 0);
    idle(2);
    read_check("flush_x7", 0, 7, saved);

    // CSR read/modify/write.
    issue(mk_csr(1, 12'h305, 2'd1, 5'd3, 64'h8000_0100));
    idle(2);
    check("mtvec_rw", csr_mtvec, 64'h8000_0100);
    read_check("mtvec_old_x1", 0, 1, 64'h0);
    issue(mk_csr(2, 12'h340, 2'd1, 5'd4, 64'h5A5A));
    issue(mk_csr(3, 12'h340, 2'd2, 5'd0, 64'hFFFF));
    issue(mk_csr(4, 12'h340, 2'd3, 5'd0, 64'hFFFF));
    idle(2);
    read_check("mscratch_rs_x0", 0, 4, 64'h5A5A);
    issue(mk_csr(0, 12'h300, 2'd2, 5'd1, 64'h8));
    idle(2);
    check("mstatus_set_mie", csr_mstatus, 64'h1808);
    issue(mk_csr(0, 12'h300, 2'd3, 5'd1, 64'h8));
    idle(2);
    check("mstatus_clr_mie", csr_mstatus, 64'h1800);

    // ecall / mret round trip.
    issue(mk_csr(0, 12'h300, 2'd2, 5'd1, 64'h8));
    idle(1);
    t = '0; t.pc = 32'h8000_0040; t.ecall = 1;
    issue(t);
    idle(1);
    check("ecall_redirect", redirect, 1);
    check("ecall_target", redirect_pc, 64'h8000_0100);
    check("ecall_mepc", csr_mepc, 64'h8000_0040);
    check("ecall_mcause", csr_mcause, 64'd11);
    check("ecall_mstatus", csr_mstatus, 64'h1880);
    idle(1);
    check("ecall_pulse_end", redirect, 0);
    t = '0; t.pc = 32'h8000_0100; t.mret = 1;
    issue(t);
    idle(1);
    check("mret_redirect", redirect, 1);
    check("mret_target", redirect_pc, 64'h8000_0040);
    check("mret_mstatus", csr_mstatus, 64'h1888);
    idle(1);
    check("mret_pulse_end", redirect, 0);

    // Same-cycle read of the register being committed.
    saved = m_gpr[9];
    raddr[AW +: AW] = 9;
    issue(mk_alu(9, 64'h55));
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("bypass_x9", rdata[XLEN +: XLEN], 64'h55);
`else
    check("nobypass_x9", rdata[XLEN +: XLEN], saved);
`endif
    idle(2);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        issue(rand_instr());
        stall = 1; rst = 1;
        step();
        rst = 0; stall = 0;
        check("midrst_wb_valid", wb_valid, 0);
        check("midrst_mstatus", csr_mstatus, 64'h1800);
      end
      cur = rand_instr();
      in_valid = $urandom_range(0, 9) < 8;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 3) == 0;
      for (int p = 0; p < NRP; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 31));
      step();
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
